// File: rtl/nano_mon_pkg.sv
// Shared constants, FSM encodings and helpers for the Nano monitor UART.
// Build option: NANO_MON_CHKSUM_EN appends a two-digit checksum before CR/LF.
package nano_mon_pkg;

  localparam logic [7:0] AsciiHash = 8'h23;
  localparam logic [7:0] AsciiCr   = 8'h0D;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiZero = 8'h30;
  localparam logic [7:0] AsciiA    = 8'h41;

`ifdef NANO_MON_CHKSUM_EN
  localparam int unsigned FRAME_LEN = 17;
`else
  localparam int unsigned FRAME_LEN = 15;
`endif

  localparam int unsigned NumSteps = 5;
  localparam logic [2:0] StepCtrl [NumSteps] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSel  = 2'd1;
  localparam logic [1:0] StSend = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return AsciiZero + {4'd0, nib};
    end
    return AsciiA + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/nano_mon_if.sv
// Monitor select/sample bus between the Nano system top and its downstream monitor.
interface nano_mon_if;
  logic [2:0] OUT_CTRL;
  logic [7:0] OUT8B;
  logic [3:0] OUT4B;

  modport master (output OUT_CTRL, input OUT8B, input OUT4B);
  modport slave  (input OUT_CTRL, output OUT8B, output OUT4B);
endinterface

// File: rtl/uart_tx_byte.sv
// UART 8N1 transmitter for one byte; start is taken only while idle.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 163
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic            busy_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [3:0]      bit_idx_q;
  logic [9:0]      shift_q;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      busy_q    <= 1'b0;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '1;
    end else if (!busy_q) begin
      if (start) begin
        busy_q    <= 1'b1;
        clk_cnt_q <= '0;
        bit_idx_q <= '0;
        shift_q   <= {1'b1, data, 1'b0};
      end
    end else if (clk_cnt_q == CntLast) begin
      clk_cnt_q <= '0;
      if (bit_idx_q == 4'd9) begin
        // Stop bit finished: line back to idle, index holds at its last value.
        busy_q  <= 1'b0;
        shift_q <= '1;
      end else begin
        bit_idx_q <= bit_idx_q + 4'd1;
        shift_q   <= {1'b1, shift_q[9:1]};
      end
    end else begin
      clk_cnt_q <= clk_cnt_q + 1'b1;
    end
  end

  assign tx   = shift_q[0];
  assign busy = busy_q;

endmodule

// File: rtl/nano_mon_uart.sv
// Captures the Nano state/flags/R snapshot over OUT_CTRL and logs it as an ASCII hex UART frame.
// Build option: NANO_MON_CHKSUM_EN adds a modulo-256 checksum (two hex digits) before CR/LF.
module nano_mon_uart
  import nano_mon_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 163,
  parameter int unsigned SETTLE_CYC   = 2
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              TRIG,
  input  logic              AUTO,
  nano_mon_if.master        mon,
  output logic              TX,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int unsigned SlotCycles = 10 * CLKS_PER_BIT + 1;
  localparam int unsigned SlotW      = $clog2(SlotCycles);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SlotCycles - 1);
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYC);
  localparam logic [4:0] CharLast   = 5'(FRAME_LEN - 1);
  localparam logic [4:0] CharCr     = 5'(FRAME_LEN - 2);

  logic [1:0]       state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [3:0]       settle_q, settle_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [4:0]       char_q, char_d;
  logic [7:0]       snap_state_q, snap_flags_q;
  logic [31:0]      snap_r_q;

  logic [7:0] ch;
  logic [2:0] r_sel;
  logic       uart_start, uart_busy;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    settle_d = settle_q;
    slot_d   = slot_q;
    char_d   = char_q;
    case (state_q)
      StIdle: begin
        if (TRIG || AUTO) begin
          state_d  = StSel;
          step_d   = '0;
          settle_d = '0;
        end
      end
      StSel: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          if (step_q == 3'(NumSteps - 1)) begin
            state_d = StSend;
            slot_d  = '0;
            char_d  = '0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StSend: begin
        // The slot counter covers start, 8 data, stop and the inter-character idle cycle.
        if (slot_q == SlotLast) begin
          slot_d = '0;
          if (char_q == CharLast) begin
            state_d = StDone;
          end else begin
            char_d = char_q + 5'd1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: begin
        state_d  = AUTO ? StSel : StIdle;
        step_d   = '0;
        settle_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q  <= StIdle;
      step_q   <= '0;
      settle_q <= '0;
      slot_q   <= '0;
      char_q   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      slot_q   <= slot_d;
      char_q   <= char_d;
    end
  end

  // Sample on the last cycle of each step; R may move between steps and that is accepted.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      snap_state_q <= '0;
      snap_flags_q <= '0;
      snap_r_q     <= '0;
    end else if (state_q == StSel && settle_q == SettleLast) begin
      case (step_q)
        3'd0: snap_state_q <= mon.OUT8B;
        3'd1: begin
          snap_r_q[7:0]     <= mon.OUT8B;
          snap_flags_q[3:0] <= mon.OUT4B;
        end
        3'd2: snap_r_q[15:8] <= mon.OUT8B;
        3'd3: begin
          snap_r_q[23:16]   <= mon.OUT8B;
          snap_flags_q[7:4] <= mon.OUT4B;
        end
        default: snap_r_q[31:24] <= mon.OUT8B;
      endcase
    end
  end

`ifdef NANO_MON_CHKSUM_EN
  logic [7:0] chksum;
  assign chksum = snap_state_q + snap_flags_q + snap_r_q[7:0] + snap_r_q[15:8]
                + snap_r_q[23:16] + snap_r_q[31:24];
`endif

  always_comb begin
    ch    = AsciiLf;
    r_sel = 3'(5'd12 - char_q);
    if (char_q == 5'd0) begin
      ch = AsciiHash;
    end else if (char_q <= 5'd2) begin
      ch = nib2ascii(char_q[0] ? snap_state_q[7:4] : snap_state_q[3:0]);
    end else if (char_q <= 5'd4) begin
      ch = nib2ascii(char_q[0] ? snap_flags_q[7:4] : snap_flags_q[3:0]);
    end else if (char_q <= 5'd12) begin
      ch = nib2ascii(snap_r_q[{r_sel, 2'b00} +: 4]);
`ifdef NANO_MON_CHKSUM_EN
    end else if (char_q == 5'd13) begin
      ch = nib2ascii(chksum[7:4]);
    end else if (char_q == 5'd14) begin
      ch = nib2ascii(chksum[3:0]);
`endif
    end else if (char_q == CharCr) begin
      ch = AsciiCr;
    end else begin
      ch = AsciiLf;
    end
  end

  assign uart_start = (state_q == StSend) && (slot_q == '0) && !uart_busy;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .CLK  (CLK),
    .NRST (NRST),
    .start(uart_start),
    .data (ch),
    .tx   (TX),
    .busy (uart_busy)
  );

  assign mon.OUT_CTRL = (state_q == StSel) ? StepCtrl[step_q] : 3'd0;
  assign BUSY         = (state_q == StSel) || (state_q == StSend);
  assign FRAME_DONE   = (state_q == StDone);

endmodule

// File: doc/nano_mon_uart.md
Name: nano_mon_uart

Overview:
- Downstream monitor for the Nano microcontroller system top. It drives that block's OUT_CTRL select lines and samples its OUT8B/OUT4B monitor outputs.
- It reassembles the full state byte, flags byte and 32-bit R word into a snapshot.
- It sends each snapshot as an ASCII hex frame over a UART 8N1 TX line for bench or host logging.
- Clocked by the same CPU clock as the system (f_CLK = 1.5625 MHz).

Parameters:
- CLKS_PER_BIT, 163, CLK cycles per UART bit (9600 baud at 1.5625 MHz).
- SETTLE_CYC, 2, cycles OUT_CTRL is held before OUT8B/OUT4B is sampled (1..15).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- NRST  in  1  reset, asynchronous, active-low.
- TRIG  in  1  one-cycle request for a single snapshot frame.
- AUTO  in  1  level; when high, frames repeat back-to-back.
- OUT_CTRL  out  3  monitor select, driven to the system top.
- OUT8B  in  8  monitor byte from the system top.
- OUT4B  in  4  monitor nibble from the system top.
- TX  out  1  UART serial output, idle high.
- BUSY  out  1  high while capturing or transmitting.
- FRAME_DONE  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (NRST low, async): OUT_CTRL=3'b000, TX=1, BUSY=0, FRAME_DONE=0, snapshot registers=0, FSM=IDLE.
  - Reset mid-frame truncates the frame immediately; TX returns high with no completion.
- FSM states: IDLE -> SEL -> SEND -> DONE -> IDLE.
- IDLE:
  - A cycle with (TRIG | AUTO)=1 moves to SEL on the next edge. BUSY goes 1 on that same edge.
  - TRIG during BUSY is ignored; there is no queue.
- SEL: five capture steps k=0..4. OUT_CTRL sequence is 0, 4, 5, 6, 7.
  - Each step lasts SETTLE_CYC+1 cycles: OUT_CTRL is set on entry, and OUT8B/OUT4B are sampled on the last cycle.
  - Sample mapping:
    - ctrl 0: OUT8B -> state.
    - ctrl 4: OUT8B -> R[7:0]; OUT4B -> flags[3:0].
    - ctrl 5: OUT8B -> R[15:8].
    - ctrl 6: OUT8B -> R[23:16]; OUT4B -> flags[7:4].
    - ctrl 7: OUT8B -> R[31:24].
  - All other OUT4B samples are discarded.
  - After step 4, OUT_CTRL returns to 0.
  - The snapshot is not atomic; the CPU may update R between steps. This is intended.
- SEND: 15 characters, index 0..14, in this order:
  - '#' (0x23)
  - state hex, high nibble first
  - flags hex
  - R hex, R[31:28] first down to R[3:0]
  - CR (0x0D)
  - LF (0x0A)
- Hex digits are uppercase: 0-9 -> 0x30+n; A-F -> 0x41+(n-10).
- UART format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is exactly CLKS_PER_BIT cycles.
  - One idle (high) cycle separates consecutive characters, so a character slot is 10*CLKS_PER_BIT+1 cycles.
- DONE (single cycle): FRAME_DONE=1 and BUSY=0.
  - If AUTO=1 in this cycle, the next state is SEL directly and BUSY re-asserts on the next edge.
- Character index and bit counters saturate at their final value; they never wrap inside a frame.

Optional Feature:
- Macro: NANO_MON_CHKSUM_EN.
- Defined: two hex characters are inserted before CR. They encode the 8-bit modulo-256 sum of state, flags, R[7:0], R[15:8], R[23:16] and R[31:24]. Frame is 17 characters.
- Undefined: frame is 15 characters and there is no checksum logic.

Decomposition:
- Shared package nano_mon_pkg holds:
  - ASCII constants: '#', CR, LF, '0', 'A'.
  - FRAME_LEN (15 or 17, chosen by the macro).
  - The OUT_CTRL step table {0, 4, 5, 6, 7}.
  - FSM state encodings.
  - Nibble-to-ASCII function.
- One sub-module, uart_tx_byte:
  - Ports: CLK, NRST, start, data[7:0], tx, busy.
  - Reset: tx=1, busy=0.
  - start is accepted only when busy=0.

Test Plan (CLKS_PER_BIT=4, SETTLE_CYC=2 for simulation):
- Reset: NRST low mid-frame -> TX=1, BUSY=0, OUT_CTRL=0 within the same cycle. Nothing transmitted after release until TRIG.
- Single frame: model drives state=0x5A, flags=0xC3, R=0x12345678, returning correct OUT8B/OUT4B for each OUT_CTRL. TRIG pulse ->
  - OUT_CTRL sequence 0, 4, 5, 6, 7, each held 3 cycles.
  - Decoded TX is "#5AC312345678\r\n".
  - FRAME_DONE pulses once and BUSY falls in the same cycle.
- Timing: frame length = 1 + 15 + 15*(10*4+1) + 1 cycles from TRIG to FRAME_DONE. Each bit is exactly 4 cycles; exactly 1 idle cycle between characters.
- Busy TRIG: TRIG pulses during the SEND phase -> ignored; exactly one frame is emitted.
- AUTO: AUTO held high for 3 frames -> SEL restarts the cycle after each FRAME_DONE. R=0xFFFFFFFF, flags=0x00 gives "#00 00FFFFFFFF" characters in uppercase hex, without spaces.
- NANO_MON_CHKSUM_EN: state=0x01, flags=0x02, R=0x03040506 -> checksum 0x15. Frame is "#010203040506" + "15" + CR LF, 17 characters.
